// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage that sits in front of a 32-bit combinational ALU. Incoming
// commands go into a small in-order FIFO. The FIFO head drives the ALU
// inputs. The ALU result is registered into a valid/ready output slot.
// A command can ask for operand A to be replaced by the previous command's
// result (forwarding). Opcodes 110/111 are flagged as illegal.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_a, cmd_b         32-bit operands
//   cmd_op               3-bit opcode (add, sub, and, or, xor, shl)
//   cmd_fwd              use the previous result as operand A
//   cmd_tag              user tag, returned with the result
//   alu_a/alu_b/alu_op   drive to the external ALU (all zero when empty)
//   alu_result           combinational result from the ALU
//   res_valid/res_ready  result handshake
//   res_data/res_tag     registered result and its tag
//   res_err              illegal opcode; res_data is forced to zero
//   fifo_count           current FIFO occupancy
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [2:0]               cmd_op,
  input  logic                     cmd_fwd,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_op,
  input  logic [31:0]              alu_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic             fwd;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             fifo_mem_q [DEPTH];
  cmd_t             fifo_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_err_q, res_err_d;
  logic [31:0]      last_result_q, last_result_d;

  logic             push;
  logic             cap;
  logic             fifo_empty;
  logic             head_illegal;
  cmd_t             head;

  // A full FIFO refuses commands even when the head pops this cycle, so the
  // ready path never depends on the result-side handshake.
  assign cmd_ready = (fifo_count_q < CNT_W'(DEPTH)) && !rst;

  assign fifo_empty   = (fifo_count_q == '0);
  assign head         = fifo_mem_q[rd_ptr_q];
  assign head_illegal = (head.op > 3'b101);
  assign push         = cmd_valid && cmd_ready;
  assign cap          = !fifo_empty && (!res_valid_q || res_ready);

  // ALU operands come straight from the head entry. Forwarding can use
  // last_result directly because the previous command is always captured
  // before this entry becomes the head.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (!fifo_empty) begin
      alu_a  = head.fwd ? last_result_q : head.a;
      alu_b  = head.b;
      alu_op = head.op;
    end
  end

  // Next-state logic for the FIFO, the result slot and the forwarding register.
  always_comb begin
    fifo_mem_d    = fifo_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_tag_d     = res_tag_q;
    res_err_d     = res_err_q;
    last_result_d = last_result_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op, fwd: cmd_fwd, tag: cmd_tag};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end

    if (cap) begin
      res_valid_d   = 1'b1;
      res_data_d    = head_illegal ? 32'd0 : alu_result;
      res_tag_d     = head.tag;
      res_err_d     = head_illegal;
      last_result_d = alu_result;
      rd_ptr_d      = rd_ptr_q + 1'b1;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case ({push, cap})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Control and result registers; reset discards all queued and held work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      res_err_q     <= 1'b0;
      last_result_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_tag_q     <= res_tag_d;
      res_err_q     <= res_err_d;
      last_result_q <= last_result_d;
    end
  end

  // FIFO storage needs no reset: entries are only read once the count says
  // they were written.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;
  assign fifo_count = fifo_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Scoreboard bench for alu_issue_stage. A behavioural ALU answers the DUT's
// ALU port. For illegal opcodes this ALU returns a junk value, so the bench
// can see that the stage masks the data. Every accepted command pushes its
// expected {data, tag, err} into a queue. A monitor pops one entry for each
// result handshake.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [2:0]       cmd_op;
  logic             cmd_fwd;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_op;
  logic [31:0]      alu_result;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t        sb_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          assertions = 0;
  int          failures = 0;
  logic [31:0] model_last = '0;

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_fwd(cmd_fwd), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_err(res_err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU arithmetic; illegal opcodes give a junk value.
  function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = aluRef(alu_a, alu_b, alu_op);

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
    end
  endtask

  // Offer one command and wait (bounded) for it to be accepted. The expected
  // result is then queued, using the bench's own forwarding register.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic fwd, input logic [TAG_W-1:0] tag);
    logic [31:0] a_eff;
    logic [31:0] r;
    exp_t        e;
    bit          ok;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_fwd   = fwd;
    cmd_tag   = tag;
    ok        = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      a_eff      = fwd ? model_last : a;
      r          = aluRef(a_eff, b, op);
      model_last = r;
      e.err      = (op > 3'b101);
      e.data     = e.err ? 32'd0 : r;
      e.tag      = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic waitDrain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Result monitor: compare each handshaken result with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("res_data", 64'(res_data), 64'(e.data));
        checkOutput("res_tag", 64'(res_tag), 64'(e.tag));
        checkOutput("res_err", 64'(res_err), 64'(e.err));
      end
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_fwd   = 1'b0;
    cmd_tag   = '0;
    res_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_res_data", 64'(res_data), 64'd0);
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("idle_alu_a", 64'(alu_a), 64'd0);

    // Latency: the result slot fills one edge after acceptance
    applyStimulus(32'd5, 32'd3, 3'b000, 1'b0, 4'd1);
    checkOutput("lat_res_valid_n", 64'(res_valid), 64'd0);
    checkOutput("lat_fifo_count", 64'(fifo_count), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("lat_res_valid_n1", 64'(res_valid), 64'd1);
    checkOutput("lat_res_data", 64'(res_data), 64'd8);
    waitDrain(20);

    // Forwarding chain: 10-4 = 6, then 6<<2 = 24
    applyStimulus(32'd10, 32'd4, 3'b001, 1'b0, 4'd2);
    applyStimulus(32'hFFFF_FFFF, 32'd2, 3'b101, 1'b1, 4'd3);
    waitDrain(20);

    // Backpressure: 1 result held in the slot + DEPTH entries queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus($urandom, $urandom, 3'($urandom_range(0, 4)), 1'b0, 4'(4 + i));
    checkOutput("bp_fifo_count", 64'(fifo_count), 64'(DEPTH));
    checkOutput("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("bp_res_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    waitDrain(40);

    // Illegal opcode, then a legal one
    applyStimulus(32'd1, 32'd1, 3'b110, 1'b0, 4'd9);
    applyStimulus(32'd2, 32'd3, 3'b000, 1'b0, 4'd10);
    waitDrain(20);

    // Reset with 3 queued and a held result; forwarding restarts from 0
    model_last = 32'd77;
    res_ready  = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(32'(100 + i), 32'd1, 3'b000, 1'b0, 4'(11 + i));
    checkOutput("prerst_fifo_count", 64'(fifo_count), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("midrst_res_valid", 64'(res_valid), 64'd0);
    sb_q.delete();
    model_last = '0;
    rst        = 1'b0;
    res_ready  = 1'b1;
    applyStimulus(32'h1234_5678, 32'd7, 3'b000, 1'b1, 4'd15);
    waitDrain(20);

    // Continuous traffic across pointer wrap: one result per cycle
    pop_cyc.delete();
    for (int i = 0; i < 2 * DEPTH; i++)
      applyStimulus($urandom, $urandom, 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    4'(i));
    waitDrain(40);
    checkOutput("tput_count", 64'(pop_cyc.size()), 64'(2 * DEPTH));
    if (pop_cyc.size() == 2 * DEPTH)
      checkOutput("tput_span", 64'(pop_cyc[2*DEPTH-1] - pop_cyc[0]), 64'(2 * DEPTH - 1));
    checkOutput("final_fifo_count", 64'(fifo_count), 64'd0);
    checkOutput("final_res_valid", 64'(res_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
